// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t  : arbiter FSM states
//   N_MAX        : widest request vector supported
//   IDX_W/TEN_W  : widths of the grant index and the tenure counter
//   next_winner  : rotating priority search returning {found, idx}
package arb_pkg;

  localparam int N_MAX = 10;
  localparam int IDX_W = 4;
  localparam int TEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

  // Search last_ptr+1, last_ptr+2, ... modulo n_req and return the first
  // requesting index. Only indices below n_req are ever examined, so request
  // bits at or above n_req are ignored. last_ptr itself is visited last.
  function automatic win_t next_winner(
    input logic [N_MAX-1:0] req,
    input logic [IDX_W-1:0] last_ptr,
    input logic [IDX_W-1:0] n_req
  );
    win_t           res;
    logic [IDX_W:0] cand;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    for (int k = 1; k <= N_MAX; k++) begin
      cand = {1'b0, last_ptr} + (IDX_W+1)'(k);
      // last_ptr < n_req and k <= n_req, so one subtraction completes the wrap
      if (cand >= {1'b0, n_req}) begin
        cand = cand - {1'b0, n_req};
      end else begin
        cand = cand;
      end
      if (!res.found && ((IDX_W+1)'(k) <= {1'b0, n_req}) && req[cand[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational 4-to-10 index decoder.
//   idx : binary index
//   en  : decode enable
//   out : 1 << idx when en=1 and idx is a legal position, otherwise all-zero
module idx_onehot_dec
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_MAX-1:0] out
);

  // Decode the index; out-of-range indices produce no grant line at all.
  always_comb begin
    out = {N_MAX{1'b0}};
    if (en && (idx <= IDX_W'(N_MAX - 1))) begin
      out = {{(N_MAX-1){1'b0}}, 1'b1} << idx;
    end else begin
      out = {N_MAX{1'b0}};
    end
  end

endmodule

// File: rtl/rr_arbiter10.sv
// Round-robin arbiter for up to 10 level-sensitive requesters with a bounded
// grant tenure. The winner index is registered and expanded to a one-hot grant.
//   clk        : clock, rising edge
//   rstn       : synchronous active-low reset
//   en         : arbitration enable; low releases the current grant, blocks new ones
//   req        : request vector (bits >= N_REQ ignored)
//   gnt_valid  : a grant is active (registered)
//   gnt_idx    : current holder index (registered)
//   gnt_onehot : one-hot of gnt_idx while gnt_valid=1, else zero (combinational)
//   preempt    : one-cycle pulse when a grant ends purely on tenure (registered)
module rr_arbiter10
  import arb_pkg::*;
#(
  parameter int N_REQ    = 10,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [N_MAX-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_MAX-1:0] gnt_onehot,
  output logic             preempt
);

  if ((N_REQ < 1) || (N_REQ > N_MAX)) begin : g_bad_n_req
    $error("rr_arbiter10: N_REQ must be within 1..10");
  end
  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_bad_hold_max
    $error("rr_arbiter10: HOLD_MAX must be within 1..255");
  end

  localparam logic [IDX_W-1:0] N_REQ_C    = IDX_W'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST_C = IDX_W'(N_REQ - 1);
  localparam logic [TEN_W-1:0] HOLD_C     = TEN_W'(HOLD_MAX);

  arb_state_t       state_r,     state_s;
  logic [IDX_W-1:0] last_ptr_r,  last_ptr_s;
  logic [TEN_W-1:0] tenure_r,    tenure_s;
  logic [IDX_W-1:0] gnt_idx_r,   gnt_idx_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic             preempt_r,   preempt_s;
  win_t             win_s;
  logic             holder_req_s;
  logic             release_s;

  assign win_s        = next_winner(req, last_ptr_r, N_REQ_C);
  assign holder_req_s = req[gnt_idx_r];
  // Any one of the three causes, or several at once, yields a single release.
  assign release_s    = !holder_req_s || !en || (tenure_r == HOLD_C);

  // State, pointer, tenure and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      last_ptr_r  <= LAST_RST_C;
      tenure_r    <= {TEN_W{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      preempt_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_ptr_r  <= last_ptr_s;
      tenure_r    <= tenure_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      preempt_r   <= preempt_s;
    end
  end

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    last_ptr_s  = last_ptr_r;
    tenure_s    = tenure_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    preempt_s   = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (en && win_s.found) begin
          state_s     = GRANT;
          gnt_idx_s   = win_s.idx;
          gnt_valid_s = 1'b1;
          tenure_s    = TEN_W'(1);
        end else begin
          state_s     = IDLE;
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          // GAP guarantees one idle cycle before the next grant; the
          // released holder becomes lowest priority for that search.
          state_s     = GAP;
          gnt_valid_s = 1'b0;
          last_ptr_s  = gnt_idx_r;
          tenure_s    = {TEN_W{1'b0}};
          preempt_s   = holder_req_s && en;
        end else begin
          // HOLD_MAX <= 255 keeps this below saturation.
          tenure_s    = tenure_r + TEN_W'(1);
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_valid_s = 1'b0;
        tenure_s    = {TEN_W{1'b0}};
      end
    endcase
  end

  assign gnt_valid = gnt_valid_r;
  assign gnt_idx   = gnt_idx_r;
  assign preempt   = preempt_r;

  idx_onehot_dec u_dec (
    .idx (gnt_idx_r),
    .en  (gnt_valid_r),
    .out (gnt_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter10.sv
// Self-checking bench for rr_arbiter10. Three instances share one stimulus:
//   a: N_REQ=10 HOLD_MAX=4, b: N_REQ=6 HOLD_MAX=4, c: N_REQ=10 HOLD_MAX=16.
// A per-instance behavioural model (holder, tenure count, last holder, search
// by modulo arithmetic) is compared every cycle; directed literals pin it down.
`timescale 1ns/1ps
module tb_rr_arbiter10;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [9:0] req;

  logic       va, vb, vc;
  logic [3:0] ia, ib, ic;
  logic [9:0] oa, ob, oc;
  logic       pa, pb, pc;

  always #5 clk = ~clk;

  rr_arbiter10 #(.N_REQ(10), .HOLD_MAX(4)) u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .req(req),
    .gnt_valid(va), .gnt_idx(ia), .gnt_onehot(oa), .preempt(pa));
  rr_arbiter10 #(.N_REQ(6), .HOLD_MAX(4)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .req(req),
    .gnt_valid(vb), .gnt_idx(ib), .gnt_onehot(ob), .preempt(pb));
  rr_arbiter10 #(.N_REQ(10), .HOLD_MAX(16)) u_dut_c (
    .clk(clk), .rstn(rstn), .en(en), .req(req),
    .gnt_valid(vc), .gnt_idx(ic), .gnt_onehot(oc), .preempt(pc));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int n_of [NI] = '{10, 6, 10};
  int h_of [NI] = '{4, 4, 16};

  bit m_valid [NI];
  int m_idx   [NI];
  int m_ten   [NI];
  int m_last  [NI];
  bit m_pre   [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester after 'last' in circular order among the n active ones, -1 if none.
  function automatic int find_winner(input logic [9:0] r, input int last, input int n);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (last + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Behavioural model: advances each instance's expected state on the clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rstn) begin
        m_valid[i] <= 1'b0;
        m_idx[i]   <= 0;
        m_ten[i]   <= 0;
        m_last[i]  <= n_of[i] - 1;
        m_pre[i]   <= 1'b0;
      end else if (m_valid[i]) begin
        if (!req[m_idx[i]] || !en || (m_ten[i] == h_of[i])) begin
          m_valid[i] <= 1'b0;
          m_last[i]  <= m_idx[i];
          m_ten[i]   <= 0;
          m_pre[i]   <= req[m_idx[i]] && en;
        end else begin
          m_ten[i]   <= m_ten[i] + 1;
          m_pre[i]   <= 1'b0;
        end
      end else begin
        int w;
        w = en ? find_winner(req, m_last[i], n_of[i]) : -1;
        m_pre[i] <= 1'b0;
        if (w >= 0) begin
          m_valid[i] <= 1'b1;
          m_idx[i]   <= w;
          m_ten[i]   <= 1;
        end
      end
    end
  end

  task automatic cmp(input int i, input logic v, input logic [3:0] ix,
                     input logic [9:0] oh, input logic p);
    logic [9:0] exp_oh;
    exp_oh = m_valid[i] ? (10'b1 << m_idx[i]) : 10'b0;
    chk($sformatf("model%0d_valid", i), 32'(v), 32'(m_valid[i]));
    chk($sformatf("model%0d_onehot", i), 32'(oh), 32'(exp_oh));
    chk($sformatf("model%0d_preempt", i), 32'(p), 32'(m_pre[i]));
    if (m_valid[i]) begin
      chk($sformatf("model%0d_idx", i), 32'(ix), 32'(m_idx[i]));
    end
  endtask

  // Cycle compare of all instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, va, ia, oa, pa);
      cmp(1, vb, ib, ob, pb);
      cmp(2, vc, ic, oc, pc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_a(input string nm, input logic v, input logic [3:0] ix,
                       input logic [9:0] oh, input logic p);
    chk({nm, "_valid"},   32'(va), 32'(v));
    chk({nm, "_idx"},     32'(ia), 32'(ix));
    chk({nm, "_onehot"},  32'(oa), 32'(oh));
    chk({nm, "_preempt"}, 32'(pa), 32'(p));
  endtask

  int seq4 [3] = '{0, 5, 0};

  initial begin
    rstn = 1'b0;
    en   = 1'b1;
    req  = 10'h3FF;
    tick(2);
    chk_en = 1'b1;

    // Reset state with every request asserted
    lit_a("t1_reset", 1'b0, 4'd0, 10'h000, 1'b0);

    // Single request, one-cycle latency, release on drop
    rstn = 1'b1;
    req  = 10'h008;
    tick(1);
    lit_a("t2_grant", 1'b1, 4'd3, 10'h008, 1'b0);
    req = 10'h000;
    tick(1);
    chk("t2_release_valid", 32'(va), 32'd0);
    chk("t2_release_preempt", 32'(pa), 32'd0);
    tick(1);

    // Full rotation with tenure preemption, HOLD_MAX=4
    rstn = 1'b0;
    req  = 10'h3FF;
    tick(1);
    rstn = 1'b1;
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        chk($sformatf("t3_g%0d_c%0d_valid", g, c), 32'(va), 32'd1);
        chk($sformatf("t3_g%0d_c%0d_idx", g, c), 32'(ia), 32'(g));
      end
      tick(1);
      chk($sformatf("t3_g%0d_gap_valid", g), 32'(va), 32'd0);
      chk($sformatf("t3_g%0d_gap_preempt", g), 32'(pa), 32'd1);
    end

    // Wrap after holder 9: 0, 5, 0
    req = 10'h021;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        chk($sformatf("t4_s%0d_c%0d_idx", g, c), 32'(ia), 32'(seq4[g]));
        chk($sformatf("t4_s%0d_c%0d_valid", g, c), 32'(va), 32'd1);
      end
      tick(1);
      chk($sformatf("t4_s%0d_gap_valid", g), 32'(va), 32'd0);
      chk($sformatf("t4_s%0d_gap_preempt", g), 32'(pa), 32'd1);
    end

    // Mid-grant disable, pointer kept across en toggle, then mid-grant reset
    req = 10'h004;
    tick(1);
    lit_a("t5_grant2", 1'b1, 4'd2, 10'h004, 1'b0);
    req = 10'h3FF;
    tick(1);
    lit_a("t5_hold2", 1'b1, 4'd2, 10'h004, 1'b0);
    en = 1'b0;
    tick(1);
    chk("t5_en_off_valid", 32'(va), 32'd0);
    chk("t5_en_off_preempt", 32'(pa), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick(1);
      chk($sformatf("t5_blocked%0d_valid", c), 32'(va), 32'd0);
    end
    en = 1'b1;
    tick(1);
    lit_a("t5_after_en", 1'b1, 4'd3, 10'h008, 1'b0);
    rstn = 1'b0;
    tick(1);
    lit_a("t5_reset_mid", 1'b0, 4'd0, 10'h000, 1'b0);
    rstn = 1'b1;
    tick(1);
    lit_a("t5_first_after_reset", 1'b1, 4'd0, 10'h001, 1'b0);

    // Masked requests on the N_REQ=6 instance
    rstn = 1'b0;
    req  = 10'h3C0;
    tick(1);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk($sformatf("t6_masked%0d_valid", c), 32'(vb), 32'd0);
      chk($sformatf("t6_masked%0d_onehot", c), 32'(ob), 32'd0);
    end
    req = 10'h3E0;
    tick(1);
    chk("t6_grant_valid", 32'(vb), 32'd1);
    chk("t6_grant_idx", 32'(ib), 32'd5);
    chk("t6_grant_onehot", 32'(ob), 32'h020);
    tick(3);
    chk("t6_hold_idx", 32'(ib), 32'd5);
    tick(1);
    chk("t6_gap_valid", 32'(vb), 32'd0);
    chk("t6_gap_preempt", 32'(pb), 32'd1);
    tick(1);
    chk("t6_regrant_idx", 32'(ib), 32'd5);
    chk("t6_regrant_valid", 32'(vb), 32'd1);

    // Tenure limit, req drop and en low on the same edge: one release, no preempt
    rstn = 1'b0;
    req  = 10'h001;
    tick(1);
    rstn = 1'b1;
    tick(4);
    lit_a("t7_tenure4", 1'b1, 4'd0, 10'h001, 1'b0);
    req = 10'h000;
    en  = 1'b0;
    tick(1);
    chk("t7_release_valid", 32'(va), 32'd0);
    chk("t7_release_preempt", 32'(pa), 32'd0);
    en = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
